pipeline_mem_arbiter: RTL

- Responder side of the pipeline's memory handshake.
- Accepts instruction-fetch requests (fetch stage) and data requests (memory stage).
- Arbitrates them onto one fixed-latency single-port RAM.
- Returns the ihit/dhit completion strobes and load data that the hazard unit and pipeline latches consume to advance or stall stages.

---
 rtl/pipeline_mem_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pipeline_mem_arbiter.sv
// pipeline_mem_arbiter: responder side of the pipeline memory handshake.
// Arbitrates instruction fetches and data accesses onto one fixed-latency
// single-port RAM and returns ihit/dhit completion strobes with load data.
module pipeline_mem_arbiter #(
  parameter int unsigned RAM_LAT = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(RAM_LAT);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      lat_addr_q, lat_addr_d;
  logic             last_cycle;

  // The access has spent its full latency once the counter reaches RAM_LAT.
  assign last_cycle = (cnt_q == LAT_C);

  // State, latency counter and latched address; reset discards any in-flight access.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lat_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_addr_q <= lat_addr_d;
    end
  end

  // Next-state and output decode; data wins in IDLE, aborts and redirects beat the hit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_addr_d = lat_addr_q;
    ihit       = 1'b0;
    dhit       = 1'b0;
    iload      = '0;
    dload      = '0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;

    case (state_q)
      IDLE: begin
        if (dREN || dWEN) begin
          state_d    = DBUSY;
          lat_addr_d = daddr;
          cnt_d      = ONE_C;
        end else if (iREN) begin
          state_d    = IBUSY;
          lat_addr_d = iaddr;
          cnt_d      = ONE_C;
        end
      end

      IBUSY: begin
        ramREN  = 1'b1;
        ramaddr = lat_addr_q;
        if (!iREN) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (iaddr != lat_addr_q) begin
          lat_addr_d = iaddr;
          cnt_d      = ONE_C;
        end else if (last_cycle) begin
          ihit    = 1'b1;
          iload   = ramload;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end

      DBUSY: begin
        ramaddr  = lat_addr_q;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramstore = dstore;
        if (!(dREN || dWEN)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (last_cycle) begin
          dhit    = 1'b1;
          dload   = ramload;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule
